// File: rtl/trap_controller_pkg.sv
//------------------------------------------------------------------------------
// trap_controller_pkg
//   Shared definitions for the user-mode trap sequencer: cause codes, FSM
//   state encodings, CSR numbers, ustatus/uie bit positions and the ustatus
//   update helpers used on trap entry and URET.
//   Configuration macro used by the importing files: TRAP_VECTORED_EN.
//   Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package trap_controller_pkg;

   // Exception cause codes (ucause[4:0], interrupt bit clear)
   localparam logic [4:0] EXC_INSTR_MIS = 5'd0;
   localparam logic [4:0] EXC_ILLEGAL   = 5'd2;
   localparam logic [4:0] EXC_EBREAK    = 5'd3;
   localparam logic [4:0] EXC_LOAD_MIS  = 5'd4;
   localparam logic [4:0] EXC_STORE_MIS = 5'd6;
   localparam logic [4:0] EXC_ECALL     = 5'd8;

   // Interrupt cause codes (ucause[4:0], interrupt bit set)
   localparam logic [4:0] IRQ_SOFT  = 5'd0;
   localparam logic [4:0] IRQ_TIMER = 5'd4;
   localparam logic [4:0] IRQ_EXT   = 5'd8;

   // Sequencer states
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_SAVE   = 3'd1;
   localparam logic [2:0] ST_STATUS = 3'd2;
   localparam logic [2:0] ST_JUMP   = 3'd3;
   localparam logic [2:0] ST_RSTAT  = 3'd4;
   localparam logic [2:0] ST_RJUMP  = 3'd5;

   // User-mode CSR numbers
   localparam logic [11:0] CSR_USTATUS = 12'h000;
   localparam logic [11:0] CSR_UIE     = 12'h004;
   localparam logic [11:0] CSR_UTVEC   = 12'h005;
   localparam logic [11:0] CSR_UEPC    = 12'h041;
   localparam logic [11:0] CSR_UCAUSE  = 12'h042;
   localparam logic [11:0] CSR_UTVAL   = 12'h043;

   // ustatus / uie bit positions
   localparam int USTATUS_UIE  = 0;
   localparam int USTATUS_UPIE = 4;
   localparam int UIE_USIE     = 0;
   localparam int UIE_UTIE     = 4;
   localparam int UIE_UEIE     = 8;

   localparam logic [1:0] UTVEC_MODE_VECTORED = 2'b01;

   typedef struct packed {
      logic [31:0] cause;
      logic [31:0] tval;
   } trap_info_t;

   function automatic logic [31:0] make_cause(input logic is_irq, input logic [4:0] code);
      return {is_irq, 26'd0, code};
   endfunction

   // Trap entry: stash the current enable in UPIE, then disable.
   function automatic logic [31:0] status_on_trap(input logic [31:0] s);
      logic [31:0] r;
      r               = s;
      r[USTATUS_UPIE] = s[USTATUS_UIE];
      r[USTATUS_UIE]  = 1'b0;
      return r;
   endfunction

   // URET: restore the enable from UPIE, then set UPIE.
   function automatic logic [31:0] status_on_uret(input logic [31:0] s);
      logic [31:0] r;
      r               = s;
      r[USTATUS_UIE]  = s[USTATUS_UPIE];
      r[USTATUS_UPIE] = 1'b1;
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/trap_irq_prioritizer.sv
//------------------------------------------------------------------------------
// trap_irq_prioritizer
//   Synchronizes the asynchronous external interrupt, gates all three sources
//   with their uie enables and the ustatus global enable, and picks the
//   highest-priority pending one (external > software > timer).
//   Ports:
//     clk, rst               clock, async active-high reset
//     int_ext                asynchronous external interrupt request
//     int_soft, int_timer    synchronous interrupt requests
//     global_en              ustatus.UIE
//     ext_en/soft_en/timer_en  uie enables
//     pending                an enabled interrupt is pending
//     code                   cause code of the winning interrupt
//   Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module trap_irq_prioritizer
   import trap_controller_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       int_ext,
   input  logic       int_soft,
   input  logic       int_timer,
   input  logic       global_en,
   input  logic       ext_en,
   input  logic       soft_en,
   input  logic       timer_en,
   output logic       pending,
   output logic [4:0] code
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   ext_sync;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], int_ext};
      end
   end

   assign ext_sync = sync_q[SYNC_STAGES-1];

   always_comb begin
      pending = 1'b0;
      code    = '0;
      if (global_en) begin
         if (ext_en && ext_sync) begin
            pending = 1'b1;
            code    = IRQ_EXT;
         end else if (soft_en && int_soft) begin
            pending = 1'b1;
            code    = IRQ_SOFT;
         end else if (timer_en && int_timer) begin
            pending = 1'b1;
            code    = IRQ_TIMER;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/trap_controller.sv
//------------------------------------------------------------------------------
// trap_controller
//   User-mode trap sequencer. Detects exceptions/interrupts at commit, writes
//   uepc/ucause/utval in one simultaneous CSR write, updates ustatus, then
//   redirects fetch to utvec. Also sequences URET (ustatus restore, jump to
//   uepc).
//   Macro TRAP_VECTORED_EN: when defined, interrupts with utvec mode 1 jump to
//   base + 4*cause; otherwise every trap jumps to the utvec base.
//   Ports:
//     iCLK, iRST                     clock, async active-high reset
//     iInstrValid/iPC/iInstr/iBadAddr  committing instruction info
//     iExc*                          exception flags
//     iUret                          committing instruction is URET
//     iIntSoft/iIntTimer/iIntExt     interrupt requests (ext is async)
//     iUSTATUS/iUTVEC/iUEPC/iUIE     CSR read-outs
//     oCSRWriteSimu, oUEPC/oUCAUSE/oUTVAL  simultaneous trap-CSR write
//     oCSRWrite/oCSRWriteAddr/oCSRWriteData ustatus write
//     oRedirect/oRedirectPC          one-cycle fetch redirect
//     oStall                         pipeline hold (combinational)
//   Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module trap_controller
   import trap_controller_pkg::*;
#(
   parameter int          SYNC_STAGES  = 2,
   parameter logic [11:0] USTATUS_ADDR = CSR_USTATUS
) (
   input  logic        iCLK,
   input  logic        iRST,
   input  logic        iInstrValid,
   input  logic [31:0] iPC,
   input  logic [31:0] iInstr,
   input  logic [31:0] iBadAddr,
   input  logic        iExcInstrMis,
   input  logic        iExcIllegal,
   input  logic        iExcEbreak,
   input  logic        iExcEcall,
   input  logic        iExcLoadMis,
   input  logic        iExcStoreMis,
   input  logic        iUret,
   input  logic        iIntSoft,
   input  logic        iIntTimer,
   input  logic        iIntExt,
   input  logic [31:0] iUSTATUS,
   input  logic [31:0] iUTVEC,
   input  logic [31:0] iUEPC,
   input  logic [31:0] iUIE,
   output logic        oCSRWriteSimu,
   output logic [31:0] oUEPC,
   output logic [31:0] oUCAUSE,
   output logic [31:0] oUTVAL,
   output logic        oCSRWrite,
   output logic [11:0] oCSRWriteAddr,
   output logic [31:0] oCSRWriteData,
   output logic        oRedirect,
   output logic [31:0] oRedirectPC,
   output logic        oStall
);

   logic [2:0]  state;
   logic [31:0] epc_q;
   logic [31:0] cause_q;
   logic [31:0] tval_q;
   logic        simu_q;

   logic        irq_pending;
   logic [4:0]  irq_code;
   logic        exc_any;
   logic        in_idle;
   logic        detect;
   logic        uret_go;
   trap_info_t  sel;
   logic [31:0] trap_target;

   trap_irq_prioritizer #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_irq (
      .clk       (iCLK),
      .rst       (iRST),
      .int_ext   (iIntExt),
      .int_soft  (iIntSoft),
      .int_timer (iIntTimer),
      .global_en (iUSTATUS[USTATUS_UIE]),
      .ext_en    (iUIE[UIE_UEIE]),
      .soft_en   (iUIE[UIE_USIE]),
      .timer_en  (iUIE[UIE_UTIE]),
      .pending   (irq_pending),
      .code      (irq_code)
   );

   assign exc_any = iExcInstrMis | iExcIllegal | iExcEbreak |
                    iExcEcall | iExcLoadMis | iExcStoreMis;
   assign in_idle = (state == ST_IDLE);
   assign detect  = in_idle & iInstrValid & (irq_pending | exc_any);
   // A URET only runs when nothing else traps on the same instruction.
   assign uret_go = in_idle & iInstrValid & iUret & ~irq_pending & ~exc_any;

   assign oStall  = ~in_idle | detect | (in_idle & iInstrValid & iUret);

   // Cause/tval selection in priority order.
   always_comb begin
      sel.cause = '0;
      sel.tval  = '0;
      if (irq_pending) begin
         sel.cause = make_cause(1'b1, irq_code);
      end else if (iExcInstrMis) begin
         sel.cause = make_cause(1'b0, EXC_INSTR_MIS);
         sel.tval  = iBadAddr;
      end else if (iExcIllegal) begin
         sel.cause = make_cause(1'b0, EXC_ILLEGAL);
         sel.tval  = iInstr;
      end else if (iExcEbreak) begin
         sel.cause = make_cause(1'b0, EXC_EBREAK);
         sel.tval  = iPC;
      end else if (iExcEcall) begin
         sel.cause = make_cause(1'b0, EXC_ECALL);
      end else if (iExcLoadMis) begin
         sel.cause = make_cause(1'b0, EXC_LOAD_MIS);
         sel.tval  = iBadAddr;
      end else if (iExcStoreMis) begin
         sel.cause = make_cause(1'b0, EXC_STORE_MIS);
         sel.tval  = iBadAddr;
      end
   end

   always_comb begin
      trap_target = {iUTVEC[31:2], 2'b00};
`ifdef TRAP_VECTORED_EN
      if ((iUTVEC[1:0] == UTVEC_MODE_VECTORED) && cause_q[31]) begin
         trap_target = {iUTVEC[31:2], 2'b00} + {25'd0, cause_q[4:0], 2'b00};
      end
`endif
   end

   // Outputs are registered alongside the state so each strobe is high for
   // exactly the cycle the FSM sits in the matching state.
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         state         <= ST_IDLE;
         epc_q         <= '0;
         cause_q       <= '0;
         tval_q        <= '0;
         simu_q        <= 1'b0;
         oCSRWrite     <= 1'b0;
         oCSRWriteData <= '0;
         oRedirect     <= 1'b0;
         oRedirectPC   <= '0;
      end else begin
         simu_q        <= 1'b0;
         oCSRWrite     <= 1'b0;
         oCSRWriteData <= '0;
         oRedirect     <= 1'b0;
         oRedirectPC   <= '0;
         case (state)
            ST_IDLE: begin
               if (detect) begin
                  state   <= ST_SAVE;
                  epc_q   <= iPC;
                  cause_q <= sel.cause;
                  tval_q  <= sel.tval;
                  simu_q  <= 1'b1;
               end else if (uret_go) begin
                  state         <= ST_RSTAT;
                  oCSRWrite     <= 1'b1;
                  oCSRWriteData <= status_on_uret(iUSTATUS);
               end
            end
            ST_SAVE: begin
               state         <= ST_STATUS;
               oCSRWrite     <= 1'b1;
               oCSRWriteData <= status_on_trap(iUSTATUS);
            end
            ST_STATUS: begin
               state       <= ST_JUMP;
               oRedirect   <= 1'b1;
               oRedirectPC <= trap_target;
            end
            ST_RSTAT: begin
               state       <= ST_RJUMP;
               oRedirect   <= 1'b1;
               oRedirectPC <= iUEPC;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign oCSRWriteSimu = simu_q;
   assign oUEPC         = simu_q ? epc_q   : '0;
   assign oUCAUSE       = simu_q ? cause_q : '0;
   assign oUTVAL        = simu_q ? tval_q  : '0;
   assign oCSRWriteAddr = USTATUS_ADDR;

   // Enable bits not used by the user-mode interrupt set, and the utvec mode
   // field in the non-vectored build.
   logic unused_bits;
   assign unused_bits = ^{iUIE[31:9], iUIE[7:5], iUIE[3:1], iUTVEC[1:0]};

endmodule

`default_nettype wire

// File: tb/tb_trap_controller.sv
//------------------------------------------------------------------------------
// tb_trap_controller
//   Self-checking bench for trap_controller: directed scenarios plus random
//   commits compared against a behavioural model of the trap rules.
//   Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_trap_controller;

`ifdef TRAP_VECTORED_EN
   localparam bit VEC = 1'b1;
`else
   localparam bit VEC = 1'b0;
`endif
   localparam int SYNC = 2;

   logic        iCLK = 1'b0;
   logic        iRST;
   logic        iInstrValid;
   logic [31:0] iPC, iInstr, iBadAddr;
   logic        iExcInstrMis, iExcIllegal, iExcEbreak, iExcEcall, iExcLoadMis, iExcStoreMis;
   logic        iUret, iIntSoft, iIntTimer, iIntExt;
   logic [31:0] iUSTATUS, iUTVEC, iUEPC, iUIE;
   logic        oCSRWriteSimu, oCSRWrite, oRedirect, oStall;
   logic [31:0] oUEPC, oUCAUSE, oUTVAL, oCSRWriteData, oRedirectPC;
   logic [11:0] oCSRWriteAddr;

   int checks = 0;
   int errors = 0;

   // transaction bookkeeping
   logic        want_valid;
   int          exp_kind;      // 0 none, 1 trap, 2 uret
   logic [31:0] exp_cause, exp_tval, exp_epc, exp_status, exp_target;
   logic [31:0] last_cause, last_tval, last_status, last_target;
   logic        saw_any;

   always #5 iCLK = ~iCLK;

   trap_controller #(.SYNC_STAGES(SYNC), .USTATUS_ADDR(12'h000)) dut (
      .iCLK(iCLK), .iRST(iRST), .iInstrValid(iInstrValid), .iPC(iPC), .iInstr(iInstr),
      .iBadAddr(iBadAddr), .iExcInstrMis(iExcInstrMis), .iExcIllegal(iExcIllegal),
      .iExcEbreak(iExcEbreak), .iExcEcall(iExcEcall), .iExcLoadMis(iExcLoadMis),
      .iExcStoreMis(iExcStoreMis), .iUret(iUret), .iIntSoft(iIntSoft), .iIntTimer(iIntTimer),
      .iIntExt(iIntExt), .iUSTATUS(iUSTATUS), .iUTVEC(iUTVEC), .iUEPC(iUEPC), .iUIE(iUIE),
      .oCSRWriteSimu(oCSRWriteSimu), .oUEPC(oUEPC), .oUCAUSE(oUCAUSE), .oUTVAL(oUTVAL),
      .oCSRWrite(oCSRWrite), .oCSRWriteAddr(oCSRWriteAddr), .oCSRWriteData(oCSRWriteData),
      .oRedirect(oRedirect), .oRedirectPC(oRedirectPC), .oStall(oStall)
   );

   function automatic logic [175:0] observed();
      return {oCSRWriteSimu, oCSRWrite, oRedirect, oStall, oUEPC, oUCAUSE, oUTVAL,
              oCSRWriteAddr, oCSRWriteData, oRedirectPC};
   endfunction

   task automatic clear_inputs();
      iInstrValid = 1'b0; want_valid = 1'b1;
      iPC = '0; iInstr = '0; iBadAddr = '0;
      iExcInstrMis = 0; iExcIllegal = 0; iExcEbreak = 0; iExcEcall = 0;
      iExcLoadMis = 0; iExcStoreMis = 0; iUret = 0;
      iIntSoft = 0; iIntTimer = 0; iIntExt = 0;
      iUSTATUS = '0; iUTVEC = '0; iUEPC = '0; iUIE = '0;
   endtask

   // Behavioural model of the trap decision, from the priority rules.
   task automatic predict();
      logic        req [3];
      logic [31:0] icode [3];
      logic        flag [6];
      logic [31:0] ecode [6];
      logic [31:0] etval [6];
      req   = '{iIntExt & iUIE[8], iIntSoft & iUIE[0], iIntTimer & iUIE[4]};
      icode = '{32'd8, 32'd0, 32'd4};
      flag  = '{iExcInstrMis, iExcIllegal, iExcEbreak, iExcEcall, iExcLoadMis, iExcStoreMis};
      ecode = '{32'd0, 32'd2, 32'd3, 32'd8, 32'd4, 32'd6};
      etval = '{iBadAddr, iInstr, iPC, 32'd0, iBadAddr, iBadAddr};
      exp_kind = 0; exp_cause = 0; exp_tval = 0; exp_epc = iPC;
      if (want_valid) begin
         if (iUSTATUS[0]) begin
            for (int i = 0; i < 3; i++) begin
               if (exp_kind == 0 && req[i]) begin
                  exp_kind = 1; exp_cause = 32'h8000_0000 + icode[i];
               end
            end
         end
         for (int i = 0; i < 6; i++) begin
            if (exp_kind == 0 && flag[i]) begin
               exp_kind = 1; exp_cause = ecode[i]; exp_tval = etval[i];
            end
         end
         if (exp_kind == 0 && iUret) exp_kind = 2;
      end
      if (exp_kind == 1) begin
         exp_status = (iUSTATUS & ~32'h11) | ((iUSTATUS & 32'h1) * 16);
         exp_target = iUTVEC & ~32'h3;
         if (VEC && (iUTVEC % 4 == 1) && exp_cause[31])
            exp_target = exp_target + 4 * (exp_cause % 32);
      end else begin
         exp_status = (iUSTATUS & ~32'h11) | ((iUSTATUS / 16) % 2) | 32'h10;
         exp_target = iUEPC;
      end
   endtask

   // Lets the interrupt synchronizer settle, commits one instruction and
   // checks five cycles of outputs against the model.
   task automatic run_txn(input string name);
      logic [175:0] exp, obs;
      logic e_simu, e_wr, e_rd, e_stall;
      logic [31:0] e_uepc, e_cause, e_tval, e_data, e_pc;
      iInstrValid = 1'b0;
      saw_any = 0; last_cause = 'x; last_tval = 'x; last_status = 'x; last_target = 'x;
      repeat (SYNC + 2) @(posedge iCLK);
      #1;
      iInstrValid = want_valid;
      predict();
      for (int s = 0; s < 5; s++) begin
         if (s > 0) begin
            @(posedge iCLK); #1;
            if (s == 1) begin
               iInstrValid = 0; iUret = 0;
               iExcInstrMis = 0; iExcIllegal = 0; iExcEbreak = 0;
               iExcEcall = 0; iExcLoadMis = 0; iExcStoreMis = 0;
            end
         end
         @(negedge iCLK);
         e_simu = 0; e_wr = 0; e_rd = 0; e_stall = 0;
         e_uepc = 0; e_cause = 0; e_tval = 0; e_data = 0; e_pc = 0;
         if (exp_kind == 1) begin
            e_stall = (s < 4);
            if (s == 1) begin e_simu = 1; e_uepc = exp_epc; e_cause = exp_cause; e_tval = exp_tval; end
            if (s == 2) begin e_wr = 1; e_data = exp_status; end
            if (s == 3) begin e_rd = 1; e_pc = exp_target; end
         end else if (exp_kind == 2) begin
            e_stall = (s < 3);
            if (s == 1) begin e_wr = 1; e_data = exp_status; end
            if (s == 2) begin e_rd = 1; e_pc = exp_target; end
         end
         exp = {e_simu, e_wr, e_rd, e_stall, e_uepc, e_cause, e_tval, 12'h000, e_data, e_pc};
         obs = observed();
         if (oCSRWriteSimu) begin last_cause = oUCAUSE; last_tval = oUTVAL; end
         if (oCSRWrite) last_status = oCSRWriteData;
         if (oRedirect) last_target = oRedirectPC;
         saw_any = saw_any | oCSRWriteSimu | oCSRWrite | oRedirect;
         checks++;
         if (obs !== exp) begin
            errors++;
            $display("FAIL %s stage %0d got %h expected %h", name, s, obs, exp);
         end
      end
   endtask

   task automatic test_reset();
      clear_inputs();
      iRST = 1'b1;
      repeat (3) @(posedge iCLK);
      @(negedge iCLK);
      checks++;
      if (observed() !== 176'd0) begin
         errors++; $display("FAIL reset outputs got %h expected 0", observed());
      end
      iRST = 1'b0;
   endtask

   task automatic test_ecall();
      clear_inputs();
      iExcEcall = 1; iPC = 32'h0040_0010; iUTVEC = 32'h0040_0100; iUSTATUS = 32'h1;
      run_txn("ecall");
      checks++;
      if ({last_cause, last_tval, last_status, last_target} !==
          {32'd8, 32'd0, 32'h10, 32'h0040_0100}) begin
         errors++;
         $display("FAIL ecall_values got %h %h %h %h expected 8 0 10 400100",
                  last_cause, last_tval, last_status, last_target);
      end
   endtask

   task automatic test_illegal_priority();
      clear_inputs();
      iExcIllegal = 1; iExcLoadMis = 1; iInstr = 32'hFFFF_FFFF; iBadAddr = 32'h1234_5678;
      iPC = 32'h0040_0020; iUTVEC = 32'h0040_0100; iUSTATUS = 32'h1;
      run_txn("illegal_over_loadmis");
      checks++;
      if ({last_cause, last_tval} !== {32'd2, 32'hFFFF_FFFF}) begin
         errors++;
         $display("FAIL illegal_priority got cause %h tval %h expected 2 ffffffff", last_cause, last_tval);
      end
   endtask

   task automatic test_ext_vectored();
      logic [31:0] tgt;
      clear_inputs();
      iIntExt = 1; iUIE = 32'h100; iUSTATUS = 32'h1; iUTVEC = 32'h0040_0101; iPC = 32'h0040_0030;
      run_txn("ext_irq");
      tgt = VEC ? 32'h0040_0120 : 32'h0040_0100;
      checks++;
      if ({last_cause, last_target} !== {32'h8000_0008, tgt}) begin
         errors++;
         $display("FAIL ext_irq got cause %h target %h expected 80000008 %h", last_cause, last_target, tgt);
      end
      iIntExt = 0;
   endtask

   task automatic test_timer_gate();
      clear_inputs();
      iIntTimer = 1; iUIE = 32'h10; iUSTATUS = 32'h0; iUTVEC = 32'h0040_0100; iPC = 32'h0040_0040;
      run_txn("timer_masked");
      checks++;
      if (saw_any !== 1'b0) begin
         errors++; $display("FAIL timer_masked got activity %b expected 0", saw_any);
      end
      iUSTATUS = 32'h1;
      run_txn("timer_enabled");
      checks++;
      if (last_cause !== 32'h8000_0004) begin
         errors++; $display("FAIL timer_enabled got cause %h expected 80000004", last_cause);
      end
   endtask

   task automatic test_uret();
      clear_inputs();
      iUret = 1; iUSTATUS = 32'h10; iUEPC = 32'h0040_0014; iPC = 32'h0040_0050;
      run_txn("uret");
      checks++;
      if ({last_status, last_target} !== {32'h11, 32'h0040_0014}) begin
         errors++;
         $display("FAIL uret got status %h target %h expected 11 400014", last_status, last_target);
      end
   endtask

   task automatic test_reset_mid_sequence();
      clear_inputs();
      iExcEcall = 1; iPC = 32'h0040_0060; iUTVEC = 32'h0040_0100; iUSTATUS = 32'h1;
      @(posedge iCLK); #1;
      iInstrValid = 1;
      @(posedge iCLK); #1;
      iInstrValid = 0; iExcEcall = 0;
      @(negedge iCLK);
      checks++;
      if (oCSRWriteSimu !== 1'b1) begin
         errors++; $display("FAIL mid_reset_save got %b expected 1", oCSRWriteSimu);
      end
      iRST = 1;
      @(posedge iCLK);
      @(negedge iCLK);
      checks++;
      if (observed() !== 176'd0) begin
         errors++; $display("FAIL mid_reset_outputs got %h expected 0", observed());
      end
      iRST = 0;
      @(posedge iCLK); @(negedge iCLK);
      checks++;
      if (observed() !== 176'd0) begin
         errors++; $display("FAIL mid_reset_no_resume got %h expected 0", observed());
      end
      iExcEcall = 1; iPC = 32'h0040_0070;
      run_txn("ecall_after_reset");
   endtask

   // Held ecall: the second trap is deferred until the first completes.
   task automatic test_back_to_back();
      logic [7:0] h_simu, h_wr, h_rd, h_st;
      clear_inputs();
      iExcEcall = 1; iPC = 32'h0040_0080; iUTVEC = 32'h0040_0100; iUSTATUS = 32'h1;
      @(posedge iCLK); #1;
      iInstrValid = 1;
      for (int e = 0; e < 8; e++) begin
         @(posedge iCLK); @(negedge iCLK);
         h_simu[e] = oCSRWriteSimu; h_wr[e] = oCSRWrite; h_rd[e] = oRedirect; h_st[e] = oStall;
      end
      iInstrValid = 0; iExcEcall = 0;
      checks++;
      if ({h_simu, h_wr, h_rd, h_st} !== {8'b0001_0001, 8'b0010_0010, 8'b0100_0100, 8'hFF}) begin
         errors++;
         $display("FAIL back_to_back got %b %b %b %b expected 00010001 00100010 01000100 11111111",
                  h_simu, h_wr, h_rd, h_st);
      end
      repeat (4) @(posedge iCLK);
   endtask

   task automatic test_random();
      for (int n = 0; n < 60; n++) begin
         clear_inputs();
         iUSTATUS = $urandom; iUIE = $urandom; iUTVEC = $urandom; iUEPC = $urandom;
         iPC = $urandom & ~32'h3; iInstr = $urandom; iBadAddr = $urandom;
         iIntExt   = ($urandom_range(0, 5) == 0);
         iIntSoft  = ($urandom_range(0, 5) == 0);
         iIntTimer = ($urandom_range(0, 5) == 0);
         iExcInstrMis = ($urandom_range(0, 9) == 0);
         iExcIllegal  = ($urandom_range(0, 9) == 0);
         iExcEbreak   = ($urandom_range(0, 9) == 0);
         iExcEcall    = ($urandom_range(0, 9) == 0);
         iExcLoadMis  = ($urandom_range(0, 9) == 0);
         iExcStoreMis = ($urandom_range(0, 9) == 0);
         iUret        = ($urandom_range(0, 3) == 0);
         want_valid   = ($urandom_range(0, 9) != 0);
         run_txn($sformatf("random_%0d", n));
      end
   endtask

   initial begin
      test_reset();
      test_ecall();
      test_illegal_priority();
      test_ext_vectored();
      test_timer_gate();
      test_uret();
      test_reset_mid_sequence();
      test_back_to_back();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
